uart_frame_assembler: RTL

- Sits between the UART receiver's byte output and the command decoder.
- Packs single-byte receive strobes into fixed-length command frames and checks that each frame's end character matches its opcode byte.
- Discards stalled partial frames after an inter-byte timeout.
- Presents each accepted frame through a 1-deep valid/ready output buffer, so byte collection continues while the decoder holds the previous frame.

---
 rtl/uart_frame_assembler_if.sv | 46 ++++
 rtl/uart_frame_assembler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_frame_assembler_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_assembler_if
// Description : Bundle between the UART byte source / command decoder and the
//               frame assembler.
//   rx_data     [7:0]            received byte
//   rx_valid                     one-cycle strobe qualifying rx_data
//   frame_out   [FRAME_BYTES*8]  assembled frame, byte k at [8k+7:8k]
//   frame_valid                  frame_out holds an unconsumed frame
//   frame_ready                  consumer accepts frame_out
//   err_endchar                 pulse: last byte != opcode, frame dropped
//   err_timeout                 pulse: stalled partial frame discarded
//   overflow                    pulse: good frame dropped, buffer full
//   byte_count  [4:0]            bytes held in the current partial frame
//   frames_ok   [CNT_W]          saturating count of frames delivered
//   master : byte source + consumer side; slave : assembler side
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_assembler_if #(
   parameter int FRAME_BYTES = 18,
   parameter int CNT_W       = 16
);
   logic [7:0]               rx_data;
   logic                     rx_valid;
   logic [FRAME_BYTES*8-1:0] frame_out;
   logic                     frame_valid;
   logic                     frame_ready;
   logic                     err_endchar;
   logic                     err_timeout;
   logic                     overflow;
   logic [4:0]               byte_count;
   logic [CNT_W-1:0]         frames_ok;

   modport master (
      output rx_data, rx_valid, frame_ready,
      input  frame_out, frame_valid, err_endchar, err_timeout, overflow,
             byte_count, frames_ok
   );

   modport slave (
      input  rx_data, rx_valid, frame_ready,
      output frame_out, frame_valid, err_endchar, err_timeout, overflow,
             byte_count, frames_ok
   );
endinterface
`default_nettype wire

// File: rtl/uart_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_assembler
// Description : Packs UART receive bytes into fixed-length command frames,
//               checks endchar == opcode, discards stalled partial frames on
//               an inter-byte timeout and presents good frames through a
//               1-deep valid/ready output buffer.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : uart_frame_assembler_if.slave (byte input, frame output,
//            status pulses and counters)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_assembler #(
   parameter int FRAME_BYTES    = 18,
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int CNT_W          = 16
) (
   input logic                   clk,
   input logic                   reset,
   uart_frame_assembler_if.slave bus
);

   localparam int               c_FW       = FRAME_BYTES * 8;
   localparam int               c_TMR_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [4:0]       c_LAST_IDX = 5'(FRAME_BYTES - 1);
   localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_COLLECT = 1'b1
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [4:0]           r_count, w_count_nxt;
   logic [c_TMR_W-1:0]   r_timer, w_timer_nxt;
   logic [c_FW-1:0]      r_shift;
   logic [c_FW-1:0]      r_frame_out;
   logic                 r_frame_valid;
   logic                 r_err_endchar;
   logic                 r_err_timeout;
   logic                 r_overflow;
   logic [CNT_W-1:0]     r_frames_ok;

   logic                 w_store;
   logic                 w_complete;
   logic                 w_expire;
   logic                 w_endchar_ok;
   logic                 w_good;
   logic                 w_load;
   logic [c_FW-1:0]      w_frame;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_timer_nxt = r_timer;
      w_store     = 1'b0;
      w_complete  = 1'b0;
      w_expire    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_timer_nxt = '0;
            if (bus.rx_valid) begin
               w_store     = 1'b1;
               w_count_nxt = 5'd1;
               w_state_nxt = S_COLLECT;
            end
         end
         S_COLLECT: begin
            // A byte on the expiry cycle takes priority over the timeout.
            if (bus.rx_valid) begin
               w_store     = 1'b1;
               w_timer_nxt = '0;
               if (r_count == c_LAST_IDX) begin
                  w_complete  = 1'b1;
                  w_count_nxt = '0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_count_nxt = r_count + 5'd1;
               end
            end else if (r_timer == c_TMR_MAX) begin
               w_expire    = 1'b1;
               w_timer_nxt = '0;
               w_count_nxt = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + c_TMR_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
            w_timer_nxt = '0;
         end
      endcase
   end

   // ------------------------------------------------------- byte storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift <= '0;
      end else if (w_store) begin
         for (int k = 0; k < FRAME_BYTES; k++) begin
            if (r_count == 5'(k)) begin
               r_shift[8*k +: 8] <= bus.rx_data;
            end
         end
      end
   end

   // The endchar is still on rx_data in the completing cycle, so the full
   // frame is the stored bytes with the top byte taken straight from input.
   always_comb begin
      w_frame              = r_shift;
      w_frame[c_FW-1 -: 8] = bus.rx_data;
   end

   assign w_endchar_ok = (bus.rx_data == r_shift[7:0]);
   assign w_good       = w_complete && w_endchar_ok;
   // Loading while the consumer accepts in the same cycle avoids a bubble.
   assign w_load       = w_good && (!r_frame_valid || bus.frame_ready);

   // ------------------------------------------------ output buffer/status
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_out   <= '0;
         r_frame_valid <= 1'b0;
         r_err_endchar <= 1'b0;
         r_err_timeout <= 1'b0;
         r_overflow    <= 1'b0;
         r_frames_ok   <= '0;
      end else begin
         r_err_endchar <= w_complete && !w_endchar_ok;
         r_err_timeout <= w_expire;
         r_overflow    <= w_good && r_frame_valid && !bus.frame_ready;
         if (w_load) begin
            r_frame_out   <= w_frame;
            r_frame_valid <= 1'b1;
            if (r_frames_ok != '1) begin
               r_frames_ok <= r_frames_ok + CNT_W'(1);
            end
         end else if (bus.frame_ready) begin
            r_frame_valid <= 1'b0;
         end
      end
   end

   assign bus.frame_out   = r_frame_out;
   assign bus.frame_valid = r_frame_valid;
   assign bus.err_endchar = r_err_endchar;
   assign bus.err_timeout = r_err_timeout;
   assign bus.overflow    = r_overflow;
   assign bus.byte_count  = r_count;
   assign bus.frames_ok   = r_frames_ok;

endmodule
`default_nettype wire
